// File: rtl/decode_pkg.sv
// Shared types and constants for the multi-lane decode stage.
package decode_pkg;

    localparam int unsigned INSTR_W = 16;

    localparam logic [3:0] OPC_NOP = 4'b0000;
    localparam logic [3:0] OPC_BR  = 4'b1100;

    // Instruction field positions
    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned IMM_BIT  = 11;
    localparam int unsigned RD_MSB   = 10;
    localparam int unsigned RD_LSB   = 8;
    localparam int unsigned RS1_MSB  = 7;
    localparam int unsigned RS1_LSB  = 5;
    localparam int unsigned RS2_MSB  = 4;
    localparam int unsigned RS2_LSB  = 2;
    localparam int unsigned IMM_MSB  = 4;
    localparam int unsigned IMM_LSB  = 0;

    // Lane record widths for the default core configuration
    localparam int unsigned LANE_DATA_W = 16;
    localparam int unsigned LANE_RAW    = 3;

    typedef struct packed {
        logic                   valid;
        logic [3:0]             opcode;
        logic [LANE_RAW-1:0]    rd;
        logic                   imm_flag;
        logic [LANE_DATA_W-1:0] op1;
        logic [LANE_DATA_W-1:0] op2;
        logic                   is_branch;
        logic [15:0]            target;
    } lane_t;

    typedef enum logic {
        ISSUE,
        SPLIT
    } state_e;

endpackage

// File: rtl/decode_lane.sv
// Combinational decode of one lane: field extraction, operand select, branch target.
module decode_lane
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RAW    = 3,
    parameter logic [3:0]  BR_OPC = OPC_BR
) (
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [15:0]        pc_i,
    input  logic [DATA_W-1:0]  rs1_data_i,
    input  logic [DATA_W-1:0]  rs2_data_i,
    output logic [3:0]         opcode_o,
    output logic [RAW-1:0]     rd_o,
    output logic [RAW-1:0]     rs1_o,
    output logic [RAW-1:0]     rs2_o,
    output logic               imm_flag_o,
    output logic               writes_rd_o,
    output logic               is_branch_o,
    output logic [DATA_W-1:0]  op1_o,
    output logic [DATA_W-1:0]  op2_o,
    output logic [15:0]        target_o
);

    logic [4:0] imm;

    // Field decode and operand/target formation
    always_comb begin
        imm         = instr_i[IMM_MSB:IMM_LSB];
        opcode_o    = instr_i[OPC_MSB:OPC_LSB];
        imm_flag_o  = instr_i[IMM_BIT];
        rd_o        = RAW'(instr_i[RD_MSB:RD_LSB]);
        rs1_o       = RAW'(instr_i[RS1_MSB:RS1_LSB]);
        rs2_o       = RAW'(instr_i[RS2_MSB:RS2_LSB]);
        is_branch_o = (opcode_o == BR_OPC);
        writes_rd_o = (opcode_o != OPC_NOP) && (opcode_o != BR_OPC);
        op1_o       = rs1_data_i;
        op2_o       = imm_flag_o ? DATA_W'(imm) : rs2_data_i;
        // Halfword-scaled signed offset, wraps modulo 2^16
        target_o    = pc_i + {{10{imm[4]}}, imm, 1'b0};
    end

endmodule

// File: rtl/decode_stage_multi.sv
// Multi-lane decode stage: per-lane decode, intra-bundle RAW splitting, output register.
module decode_stage_multi
    import decode_pkg::*;
#(
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NREG    = 8,
    parameter logic [3:0]  BR_OPC  = OPC_BR,
    localparam int unsigned RAW    = $clog2(NREG)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTR_W*ISSUE_W-1:0]    in_instr,
    input  logic [15:0]                   in_pc,
    output logic [2*RAW*ISSUE_W-1:0]      rf_raddr,
    input  logic [2*DATA_W*ISSUE_W-1:0]   rf_rdata,
    output logic [ISSUE_W-1:0]            out_valid,
    input  logic                          out_ready,
    output logic [4*ISSUE_W-1:0]          out_opcode,
    output logic [RAW*ISSUE_W-1:0]        out_rd,
    output logic [ISSUE_W-1:0]            out_imm_flag,
    output logic [DATA_W*ISSUE_W-1:0]     out_op1,
    output logic [DATA_W*ISSUE_W-1:0]     out_op2,
    output logic [ISSUE_W-1:0]            out_is_branch,
    output logic [16*ISSUE_W-1:0]         out_branch_target
);

    state_e                         state_q, state_d;
    logic [INSTR_W*ISSUE_W-1:0]     hold_instr_q, hold_instr_d;
    logic [15:0]                    hold_pc_q, hold_pc_d;
    logic [ISSUE_W-1:0]             mask_q, mask_d;

    logic [INSTR_W*ISSUE_W-1:0]     src_instr;
    logic [15:0]                    src_pc;

    logic [ISSUE_W-1:0][3:0]        l_opcode;
    logic [ISSUE_W-1:0][RAW-1:0]    l_rd, l_rs1, l_rs2;
    logic [ISSUE_W-1:0]             l_imm, l_wr, l_br;
    logic [ISSUE_W-1:0][DATA_W-1:0] l_op1, l_op2;
    logic [ISSUE_W-1:0][15:0]       l_tgt;

    logic [ISSUE_W-1:0]             active, haz, emit, rem;
    logic                           cut_seen;
    logic                           slot_free, fire;

    logic [ISSUE_W-1:0]             valid_q, valid_d;
    logic [ISSUE_W-1:0][3:0]        opcode_q, opcode_d;
    logic [ISSUE_W-1:0][RAW-1:0]    rd_q, rd_d;
    logic [ISSUE_W-1:0]             imm_q, imm_d;
    logic [ISSUE_W-1:0][DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [ISSUE_W-1:0]             br_q, br_d;
    logic [ISSUE_W-1:0][15:0]       tgt_q, tgt_d;

    // While splitting, decode runs on the held bundle so the RF reads follow it
    assign src_instr = (state_q == SPLIT) ? hold_instr_q : in_instr;
    assign src_pc    = (state_q == SPLIT) ? hold_pc_q : in_pc;

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
        decode_lane #(
            .DATA_W (DATA_W),
            .RAW    (RAW),
            .BR_OPC (BR_OPC)
        ) u_lane (
            .instr_i     (src_instr[INSTR_W*k +: INSTR_W]),
            .pc_i        (src_pc + 16'(2 * k)),
            .rs1_data_i  (rf_rdata[2*DATA_W*k +: DATA_W]),
            .rs2_data_i  (rf_rdata[2*DATA_W*k + DATA_W +: DATA_W]),
            .opcode_o    (l_opcode[k]),
            .rd_o        (l_rd[k]),
            .rs1_o       (l_rs1[k]),
            .rs2_o       (l_rs2[k]),
            .imm_flag_o  (l_imm[k]),
            .writes_rd_o (l_wr[k]),
            .is_branch_o (l_br[k]),
            .op1_o       (l_op1[k]),
            .op2_o       (l_op2[k]),
            .target_o    (l_tgt[k])
        );
        assign rf_raddr[2*RAW*k +: 2*RAW] = {l_rs2[k], l_rs1[k]};
    end

    // Hazard matrix over the not-yet-emitted lanes; emit up to the first hazard
    always_comb begin
        active   = (state_q == SPLIT) ? mask_q : '1;
        haz      = '0;
        emit     = '0;
        rem      = '0;
        cut_seen = 1'b0;
        for (int j = 1; j < ISSUE_W; j++) begin
            for (int i = 0; i < j; i++) begin
                // Lanes already emitted are inactive, so they never cause a hazard here
                if (active[i] && l_wr[i] &&
                    ((l_rd[i] == l_rs1[j]) || (!l_imm[j] && (l_rd[i] == l_rs2[j])))) begin
                    haz[j] = 1'b1;
                end
            end
        end
        for (int j = 0; j < ISSUE_W; j++) begin
            if (active[j]) begin
                if (haz[j]) cut_seen = 1'b1;
                if (cut_seen) rem[j] = 1'b1;
                else          emit[j] = 1'b1;
            end
        end
    end

    assign slot_free = (valid_q == '0) || out_ready;
    assign in_ready  = (state_q == ISSUE) && slot_free && !flush;
    assign fire      = !flush && slot_free && ((state_q == ISSUE) ? in_valid : 1'b1);

    // FSM next state, hold register and remaining-lane mask
    always_comb begin
        state_d      = state_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        mask_d       = mask_q;
        if (flush) begin
            state_d      = ISSUE;
            hold_instr_d = '0;
            hold_pc_d    = '0;
            mask_d       = '0;
        end else if (fire) begin
            if (rem != '0) begin
                state_d = SPLIT;
                mask_d  = rem;
                if (state_q == ISSUE) begin
                    hold_instr_d = in_instr;
                    hold_pc_d    = in_pc;
                end
            end else begin
                state_d      = ISSUE;
                mask_d       = '0;
                hold_instr_d = '0;
                hold_pc_d    = '0;
            end
        end
    end

    // Output register next state; lanes not emitted are zeroed
    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        br_d     = br_q;
        tgt_d    = tgt_q;
        if (flush) begin
            valid_d = '0;
        end else if (slot_free) begin
            if (fire) begin
                valid_d = emit;
                for (int k = 0; k < ISSUE_W; k++) begin
                    opcode_d[k] = emit[k] ? l_opcode[k] : '0;
                    rd_d[k]     = emit[k] ? l_rd[k]     : '0;
                    imm_d[k]    = emit[k] ? l_imm[k]    : 1'b0;
                    op1_d[k]    = emit[k] ? l_op1[k]    : '0;
                    op2_d[k]    = emit[k] ? l_op2[k]    : '0;
                    br_d[k]     = emit[k] ? l_br[k]     : 1'b0;
                    tgt_d[k]    = emit[k] ? l_tgt[k]    : '0;
                end
            end else begin
                valid_d = '0;
            end
        end
    end

    // State, hold and mask registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ISSUE;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            mask_q       <= mask_d;
        end
    end

    // Output register toward issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= '0;
            opcode_q <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            br_q     <= '0;
            tgt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            br_q     <= br_d;
            tgt_q    <= tgt_d;
        end
    end

    assign out_valid         = valid_q;
    assign out_opcode        = opcode_q;
    assign out_rd            = rd_q;
    assign out_imm_flag      = imm_q;
    assign out_op1           = op1_q;
    assign out_op2           = op2_q;
    assign out_is_branch     = br_q;
    assign out_branch_target = tgt_q;

endmodule

// File: tb/tb_decode_stage_multi.sv
// Directed bench for decode_stage_multi: vector table plus split/flush/backpressure sequences.
module tb_decode_stage_multi;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [15:0] in_pc;
    logic [11:0] rf_raddr;
    logic [63:0] rf_rdata;
    logic [1:0]  out_valid;
    logic        out_ready;
    logic [7:0]  out_opcode;
    logic [5:0]  out_rd;
    logic [1:0]  out_imm_flag;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [1:0]  out_is_branch;
    logic [31:0] out_branch_target;

    logic [15:0] rf [8];
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] instr;
        logic [15:0] pc;
        logic [1:0]  valid;
        logic [7:0]  opcode;
        logic [5:0]  rd;
        logic [1:0]  imm;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  br;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs [5];

    decode_stage_multi #(
        .ISSUE_W (2),
        .DATA_W  (16),
        .NREG    (8),
        .BR_OPC  (4'b1100)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_instr          (in_instr),
        .in_pc             (in_pc),
        .rf_raddr          (rf_raddr),
        .rf_rdata          (rf_rdata),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_opcode        (out_opcode),
        .out_rd            (out_rd),
        .out_imm_flag      (out_imm_flag),
        .out_op1           (out_op1),
        .out_op2           (out_op2),
        .out_is_branch     (out_is_branch),
        .out_branch_target (out_branch_target)
    );

    always #5 clk = ~clk;

    // Register file model: same-cycle read
    always_comb begin
        rf_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            rf_rdata[32*k +: 16]      = rf[rf_raddr[6*k +: 3]];
            rf_rdata[32*k + 16 +: 16] = rf[rf_raddr[6*k + 3 +: 3]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two-step split of a bundle whose lane 1 depends on lane 0 (lane 0 = 0x1328, writes r3)
    task automatic split_seq(input string tag, input logic [31:0] instr, input logic [5:0] raddr1,
                             input logic [2:0] rd1, input logic [15:0] op1_1,
                             input logic [15:0] op2_1, input logic [15:0] tgt1);
        in_instr = instr;
        in_pc    = 16'h0100;
        in_valid = 1'b1;
        #1;
        check({tag, " accept ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check({tag, " c1 valid"}, 64'(out_valid), 64'b01);
        check({tag, " c1 in_ready"}, 64'(in_ready), 64'd0);
        check({tag, " c1 lane0 rd"}, 64'(out_rd[2:0]), 64'd3);
        check({tag, " c1 lane0 op1"}, 64'(out_op1[15:0]), 64'd5);
        check({tag, " c1 lane1 raddr"}, 64'(rf_raddr[11:6]), 64'(raddr1));
        tick();
        check({tag, " c2 valid"}, 64'(out_valid), 64'b10);
        check({tag, " c2 lane1 rd"}, 64'(out_rd[5:3]), 64'(rd1));
        check({tag, " c2 lane1 op1"}, 64'(out_op1[31:16]), 64'(op1_1));
        check({tag, " c2 lane1 op2"}, 64'(out_op2[31:16]), 64'(op2_1));
        check({tag, " c2 lane1 target"}, 64'(out_branch_target[31:16]), 64'(tgt1));
        check({tag, " c2 lane0 zeroed"}, 64'(out_opcode[3:0]), 64'd0);
        check({tag, " c2 in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rf[0] = 16'd0;  rf[1] = 16'd5;  rf[2] = 16'd7;  rf[3] = 16'd9;
        rf[4] = 16'd11; rf[5] = 16'd13; rf[6] = 16'd15; rf[7] = 16'd17;

        vecs[0] = '{32'h295F_1328, 16'h0100, 2'b11, 8'h21, 6'h0B, 2'b10,
                    32'h0007_0005, 32'h001F_0007, 2'b00, 32'h0100_0110};
        vecs[1] = '{32'hC81E_C81E, 16'h0100, 2'b11, 8'hCC, 6'h00, 2'b11,
                    32'h0000_0000, 32'h001E_001E, 2'b11, 32'h00FE_00FC};
        vecs[2] = '{32'h3204_0000, 16'hFFFE, 2'b11, 8'h30, 6'h10, 2'b00,
                    32'h0000_0000, 32'h0005_0000, 2'b00, 32'h0008_FFFE};
        vecs[3] = '{32'h4720_C100, 16'h1234, 2'b11, 8'h4C, 6'h39, 2'b00,
                    32'h0005_0000, 32'h0000_0000, 2'b01, 32'h1236_1234};
        vecs[4] = '{32'h280C_1328, 16'h0100, 2'b11, 8'h21, 6'h03, 2'b10,
                    32'h0000_0005, 32'h000C_0007, 2'b00, 32'h011A_0110};

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_instr  = '0;
        in_pc     = '0;
        #12;
        check("reset valid", 64'(out_valid), 64'd0);
        check("reset opcode", 64'(out_opcode), 64'd0);
        check("reset target", 64'(out_branch_target), 64'd0);
        reset_n = 1'b1;
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);
        tick();

        // Back-to-back hazard-free bundles at full throughput
        for (int v = 0; v < 5; v++) begin
            in_instr = vecs[v].instr;
            in_pc    = vecs[v].pc;
            in_valid = 1'b1;
            #1;
            check($sformatf("v%0d in_ready", v), 64'(in_ready), 64'd1);
            tick();
            check($sformatf("v%0d valid", v), 64'(out_valid), 64'(vecs[v].valid));
            check($sformatf("v%0d opcode", v), 64'(out_opcode), 64'(vecs[v].opcode));
            check($sformatf("v%0d rd", v), 64'(out_rd), 64'(vecs[v].rd));
            check($sformatf("v%0d imm", v), 64'(out_imm_flag), 64'(vecs[v].imm));
            check($sformatf("v%0d op1", v), 64'(out_op1), 64'(vecs[v].op1));
            check($sformatf("v%0d op2", v), 64'(out_op2), 64'(vecs[v].op2));
            check($sformatf("v%0d branch", v), 64'(out_is_branch), 64'(vecs[v].br));
            check($sformatf("v%0d target", v), 64'(out_branch_target), 64'(vecs[v].tgt));
        end
        in_valid = 1'b0;

        // Asynchronous reset while a group is held in the output register
        out_ready = 1'b0;
        check("pre-reset valid", 64'(out_valid), 64'b11);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset valid", 64'(out_valid), 64'd0);
        check("async reset op2", 64'(out_op2), 64'd0);
        check("async reset rd", 64'(out_rd), 64'd0);
        #2;
        reset_n = 1'b1;
        #1;
        check("release in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();

        // RAW on rs1, then RAW on rs2
        split_seq("raw rs1", 32'h1460_1328, 6'h03, 3'd4, 16'd9, 16'd0, 16'h0102);
        split_seq("raw rs2", 32'h500C_1328, 6'h18, 3'd0, 16'd0, 16'd9, 16'h011A);

        // Flush while the second half of a split is pending
        in_instr = 32'h1460_1328;
        in_pc    = 16'h0100;
        in_valid = 1'b1;
        tick();
        check("flush c1 valid", 64'(out_valid), 64'b01);
        in_instr = vecs[0].instr;
        flush    = 1'b1;
        #1;
        check("flush in_ready", 64'(in_ready), 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush c2 valid", 64'(out_valid), 64'd0);
        #1;
        check("flush state issue", 64'(in_ready), 64'd1);
        tick();
        check("flush lane1 dropped", 64'(out_valid), 64'd0);

        // Backpressure: group held for three cycles, then released
        in_instr  = vecs[0].instr;
        in_pc     = vecs[0].pc;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        check("bp accept ready", 64'(in_ready), 64'd1);
        tick();
        in_instr = vecs[1].instr;
        in_pc    = vecs[1].pc;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d in_ready", c), 64'(in_ready), 64'd0);
            check($sformatf("bp%0d valid", c), 64'(out_valid), 64'b11);
            check($sformatf("bp%0d op2", c), 64'(out_op2), 64'(vecs[0].op2));
            check($sformatf("bp%0d target", c), 64'(out_branch_target), 64'(vecs[0].tgt));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp next valid", 64'(out_valid), 64'b11);
        check("bp next opcode", 64'(out_opcode), 64'(vecs[1].opcode));
        check("bp next target", 64'(out_branch_target), 64'(vecs[1].tgt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage_multi.md
Name: decode_stage_multi

Overview:
- Parametrised multi-lane decode stage for the superscalar core. Successor to the single-issue decoder.
- Each cycle it accepts an ISSUE_W-wide fetch bundle of 16-bit instructions and drives register-file read addresses. It registers decoded fields and operand values toward issue.
- Adds over the previous generation:
  - valid/ready handshakes on both sides;
  - per-lane valids;
  - PC-relative branch targets;
  - splitting of bundles that contain an intra-bundle RAW dependence.

Parameters:
- ISSUE_W, 2, lanes per bundle (1..4).
- DATA_W, 16, operand width.
- NREG, 8, architectural registers. RAW = clog2(NREG) = 3.
- BR_OPC, 4'b1100, branch opcode.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  branch-taken flush from execute.
- in_valid  in  1  fetch bundle valid.
- in_ready  out  1  decode accepts the bundle.
- in_instr  in  16*ISSUE_W  lane k at bits [16k+15:16k].
- in_pc  in  16  PC of lane 0. Lane k PC = in_pc + 2k.
- rf_raddr  out  2*RAW*ISSUE_W  per lane {rs2, rs1} read addresses; combinational.
- rf_rdata  in  2*DATA_W*ISSUE_W  per lane {rs2 value, rs1 value}; combinational return, same cycle.
- out_valid  out  ISSUE_W  per-lane valid of the output register.
- out_ready  in  1  issue accepts the whole output group.
- out_opcode  out  4*ISSUE_W  decoded opcode.
- out_rd  out  RAW*ISSUE_W  destination register.
- out_imm_flag  out  ISSUE_W  immediate form.
- out_op1  out  DATA_W*ISSUE_W  rs1 value.
- out_op2  out  DATA_W*ISSUE_W  rs2 value, or zero-extended imm[4:0].
- out_is_branch  out  ISSUE_W  opcode == BR_OPC.
- out_branch_target  out  16*ISSUE_W  lane PC + (sext(imm[4:0]) << 1), modulo 2^16.

Behaviour:
- Reset (reset_n low, async):
  - all out_* = 0;
  - state = ISSUE;
  - hold bundle and remaining-lane mask cleared.
  - Deassertion is synchronous to clk.
- Instruction format:
  - [15:12] opcode, [11] imm flag, [10:8] rd, [7:5] rs1.
  - [4:2] rs2 when imm = 0.
  - [4:0] imm when imm = 1.
  - Opcode 0000 is NOP.
- Write rule: a lane writes rd iff its opcode is not NOP and not BR_OPC.
- Hazard rule: lane j has a hazard if some earlier lane i < j within the same group writes rd, and that rd equals lane j's rs1, or equals its rs2 when lane j has imm = 0.
- Output slot is free when out_valid == 0 or out_ready == 1.
- Output register update:
  - When the slot is free and a group is emitted: update all fields, set out_valid per lane, zero fields of invalid lanes.
  - When the slot is free and nothing is emitted: out_valid <= 0.
  - Otherwise hold all fields.
- State ISSUE:
  - rf_raddr is sourced from in_instr.
  - in_ready = slot free and !flush.
  - On in_valid && in_ready, compute k = first hazard lane.
  - No hazard: emit lanes 0..ISSUE_W-1; stay in ISSUE.
  - Hazard: emit lanes 0..k-1, latch bundle and PC into the hold register, set remaining mask to lanes k..ISSUE_W-1, go to SPLIT.
- State SPLIT:
  - in_ready = 0; rf_raddr is sourced from the hold register.
  - When the slot is free: recompute hazards starting at the lowest remaining lane (lane k's own dependence on lane k-1 is already satisfied), then emit up to the next hazard and clear those lanes from the mask.
  - Mask becomes empty: return to ISSUE.
  - Lane PCs stay relative to the held lane-0 PC.
- Latency:
  - One cycle from accepted bundle to out_valid.
  - A split bundle occupies one extra cycle per split point.
  - Full throughput is one bundle per cycle when there are no hazards and out_ready = 1.
- Flush (highest priority after reset):
  - At the next edge: out_valid <= 0, state <= ISSUE, hold register and mask cleared.
  - A bundle presented in the flush cycle is not accepted (in_ready = 0).
- Backpressure: with out_ready = 0 and out_valid != 0, all outputs are stable and nothing is accepted.

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants (OPC_NOP, OPC_BR);
  - INSTR_W = 16;
  - field-position localparams;
  - the decoded-lane struct {valid, opcode, rd, imm_flag, op1, op2, is_branch, target};
  - the state enum {ISSUE, SPLIT}.
- One sub-module, decode_lane: purely combinational field extraction, operand select, and target adder for one lane. The top instantiates it ISSUE_W times and adds the hazard matrix, FSM, hold register and output register.

Test Plan:
- Reset: drive reset_n = 0 mid-operation with out_valid = 2'b11 → all outputs 0 immediately; in_ready = 1 after release.
- No hazard: in_instr = {0x295F, 0x1328}, in_pc = 0x0100, rf returns r1 = 5, r2 = 7 → next cycle:
  - out_valid = 2'b11;
  - lane0 opcode 1, rd 3, op1 = 5, op2 = 7;
  - lane1 imm_flag = 1, rd 1, op2 = 0x001F.
- RAW split: bundle {0x1460 (reads r3), 0x1328 (writes r3)} →
  - cycle 1: out_valid = 2'b01, in_ready = 0;
  - cycle 2: out_valid = 2'b10, lane1 rd = 4, rs1 addr 3;
  - in_ready returns to 1 in cycle 2.
- Branch: lane0 = 0xC81E, lane1 = 0xC81E, in_pc = 0x0100 →
  - out_is_branch = 2'b11;
  - targets 0x00FC and 0x00FE.
- Flush during SPLIT: assert flush in cycle 1 of the RAW split → cycle 2: out_valid = 0, state ISSUE, lane1 never emitted.
- Backpressure: hold out_ready = 0 for 3 cycles with a valid group → outputs unchanged, in_ready = 0. Release → next bundle accepted the same cycle.
